// File: rtl/i2s_frame_rx_if.sv
// i2s_frame_rx_if: valid/ready word stream carrying a channel tag.
// master drives data/chan/valid, slave returns ready.
interface i2s_frame_rx_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] m_data;
  logic              m_chan;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_chan,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_chan,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/i2s_frame_rx.sv
// i2s_frame_rx: lr_clk-framed serial word capture into a tagged FWFT FIFO.
// Define I2S_FRAME_RX_PEAK_EN to enable the peak-magnitude tracker.
module i2s_frame_rx #(
  parameter int WORD_W     = 32,
  parameter int BIT_OFFSET = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lr_clk,
  input  logic              sd_in,
  i2s_frame_rx_if.master    m,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clear_flags,
  output logic [WORD_W-1:0] peak_abs
);
  localparam int BW = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [1:0] WAIT_LAST = 2'(BIT_OFFSET - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic              r_lr_q;
  logic              r_chan;
  logic              r_push;
  logic [1:0]        r_wcnt;
  logic [BW-1:0]     r_bcnt;
  logic [WORD_W-1:0] r_shift;
  logic              w_edge;
  logic              w_short;

  assign w_edge  = lr_clk != r_lr_q;
  assign w_short = w_edge &&
                   (r_state == S_WAIT || r_state == S_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lr_q  <= lr_clk;
      r_chan  <= 1'b0;
      r_push  <= 1'b0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_lr_q <= lr_clk;
      r_push <= 1'b0;
      if (w_edge) begin
        // any edge restarts framing; a pending push is already in r_push
        r_chan <= lr_clk;
        r_wcnt <= 2'd1;
        r_bcnt <= '0;
        if (BIT_OFFSET == 0) begin
          r_shift <= {{(WORD_W-1){1'b0}}, sd_in};
          r_bcnt  <= BW'(1);
          r_state <= S_SHIFT;
        end else if (BIT_OFFSET == 1) begin
          r_state <= S_SHIFT;
        end else begin
          r_state <= S_WAIT;
        end
      end else begin
        unique case (r_state)
          S_WAIT: begin
            r_wcnt <= r_wcnt + 2'd1;
            if (r_wcnt == WAIT_LAST)
              r_state <= S_SHIFT;
          end
          S_SHIFT: begin
            r_shift <= {r_shift[WORD_W-2:0], sd_in};
            r_bcnt  <= r_bcnt + BW'(1);
            if (r_bcnt == BIT_LAST) begin
              r_state <= S_HOLD;
              r_push  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [WORD_W:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_cnt;
  logic            w_full;
  logic            w_pop;
  logic            w_acc;
  logic            w_drop;

  assign w_full = r_cnt == CNT_FULL;
  assign w_pop  = m.m_valid && m.m_ready;
  assign w_acc  = r_push && (!w_full || w_pop);
  assign w_drop = r_push && w_full && !w_pop;

  assign m.m_valid = r_cnt != '0;
  assign m.m_data  = m.m_valid ? r_mem[r_rd][WORD_W-1:0] : '0;
  assign m.m_chan  = m.m_valid ? r_mem[r_rd][WORD_W] : 1'b0;

  always_ff @(posedge clk) begin
    if (w_acc)
      r_mem[r_wr] <= {r_chan, r_shift};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_acc) - (AW+1)'(w_pop);
    end
  end

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_drop)
        overflow <= 1'b1;
      else if (clear_flags)
        overflow <= 1'b0;
      if (w_short)
        frame_err <= 1'b1;
      else if (clear_flags)
        frame_err <= 1'b0;
    end
  end

`ifdef I2S_FRAME_RX_PEAK_EN
  localparam logic [WORD_W-1:0] ONE = WORD_W'(1);
  localparam logic [WORD_W-1:0] POS_MAX = {1'b0, {(WORD_W-1){1'b1}}};

  logic [WORD_W-1:0] r_peak;
  logic [WORD_W-1:0] w_abs;
  logic [WORD_W-1:0] w_base;

  // the most negative word has no positive twin, so it saturates
  assign w_abs = !r_shift[WORD_W-1] ? r_shift :
                 (r_shift[WORD_W-2:0] == '0) ? POS_MAX :
                 (~r_shift + ONE);
  assign w_base = clear_flags ? '0 : r_peak;

  always_ff @(posedge clk) begin
    if (!rst)
      r_peak <= '0;
    else if (w_acc && (w_abs > w_base))
      r_peak <= w_abs;
    else
      r_peak <= w_base;
  end

  assign peak_abs = r_peak;
`else
  assign peak_abs = '0;
`endif
endmodule

// File: tb/tb_i2s_frame_rx.sv
// tb_i2s_frame_rx: frame table, corner sequences and random frames
// checked against a queue-based model of the receiver.
`timescale 1ns/1ps
module tb_i2s_frame_rx;
  localparam int W  = 32;
  localparam int BO = 1;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lr_clk = 1'b1;
  logic         sd_in = 1'b0;
  logic         clear_flags = 1'b0;
  logic         overflow;
  logic         frame_err;
  logic [W-1:0] peak_abs;

  i2s_frame_rx_if #(.WORD_W(W)) mif ();

  i2s_frame_rx #(
    .WORD_W(W),
    .BIT_OFFSET(BO),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lr_clk(lr_clk),
    .sd_in(sd_in),
    .m(mif),
    .overflow(overflow),
    .frame_err(frame_err),
    .clear_flags(clear_flags),
    .peak_abs(peak_abs)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    longint s;
    longint lim;
    s = longint'($signed(v));
    lim = (longint'(1) << (W-1)) - 1;
    if (s < 0) s = -s;
    if (s > lim) s = lim;
    return s[W-1:0];
  endfunction

  // reference model: frame index counting from each lr_clk edge
  logic [W:0]   mq[$];
  logic         md_ovf = 1'b0;
  logic         md_fe = 1'b0;
  logic [W-1:0] md_peak = '0;
  logic         md_lr = 1'b0;
  logic         md_ch = 1'b0;
  logic [W-1:0] md_w = '0;
  int           md_idx = -1;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      md_ovf = 1'b0;
      md_fe = 1'b0;
      md_peak = '0;
      md_lr = lr_clk;
      md_idx = -1;
    end else begin
      bit edge_c, push, pop, short_f, drop;
      logic [W:0] pv;
      logic [W-1:0] base;
      edge_c = lr_clk != md_lr;
      md_lr = lr_clk;
      push = md_idx == BO + W;
      pv = {md_ch, md_w};
      short_f = edge_c && md_idx >= 0 && md_idx < BO + W;
      pop = mq.size() > 0 && mif.m_ready;
      drop = 1'b0;
      if (edge_c) begin
        md_idx = 0;
        md_ch = lr_clk;
        md_w = '0;
      end
      if (md_idx >= BO && md_idx < BO + W)
        md_w = md_w * 2 + W'(sd_in);
      if (md_idx >= 0 && md_idx < 100000)
        md_idx++;
      base = clear_flags ? '0 : md_peak;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < D) begin
          mq.push_back(pv);
`ifdef I2S_FRAME_RX_PEAK_EN
          if (mag(pv[W-1:0]) > base) base = mag(pv[W-1:0]);
`endif
        end else begin
          drop = 1'b1;
        end
      end
      md_peak = base;
      md_ovf = drop ? 1'b1 : (clear_flags ? 1'b0 : md_ovf);
      md_fe = short_f ? 1'b1 : (clear_flags ? 1'b0 : md_fe);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 64'(mif.m_valid), 64'(mq.size() > 0));
      if (mq.size() > 0)
        check("head", 64'({mif.m_chan, mif.m_data}), 64'(mq[0]));
      check("overflow", 64'(overflow), 64'(md_ovf));
      check("frame_err", 64'(frame_err), 64'(md_fe));
      check("peak_abs", 64'(peak_abs), 64'(md_peak));
    end
  end

  logic [W:0] got[$];
  always @(negedge clk)
    if (rst && mif.m_valid === 1'b1 && mif.m_ready === 1'b1)
      got.push_back({mif.m_chan, mif.m_data});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // rdy: 0/1 fixed, 2 random; rdy_k forces ready high at that index
  task automatic frame(input bit ch, input logic [W-1:0] wd,
                       input int len, input int rdy,
                       input bit clr, input int rdy_k);
    for (int k = 0; k < len; k++) begin
      lr_clk = ch;
      sd_in = (k >= BO && k < BO + W) ? wd[W-1-(k-BO)]
                                      : 1'($urandom);
      if (k == rdy_k) mif.m_ready = 1'b1;
      else if (rdy == 2) mif.m_ready = ($urandom % 4) != 0;
      else mif.m_ready = rdy[0];
      clear_flags = clr && k == 0;
      tick();
    end
    clear_flags = 1'b0;
  endtask

  typedef struct {
    bit         ch;
    logic [W-1:0] wd;
    int         len;
    int         rdy;
    bit         clr;
    bit         e_ovf;
    bit         e_fe;
  } vec_t;

  vec_t tv[10];
  logic [W:0] exp_a[8];
  logic [W:0] exp_b[4];

  initial begin
    tv[0] = '{1'b0, 32'hA5A5_0F0F, 40, 1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 32'hFFFF_FFFE, 40, 1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 32'h1111_1111, 40, 0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b1, 32'h2222_2222, 40, 0, 1'b0, 1'b0, 1'b0};
    tv[4] = '{1'b0, 32'h3333_3333, 40, 0, 1'b0, 1'b0, 1'b0};
    tv[5] = '{1'b1, 32'h4444_4444, 40, 0, 1'b0, 1'b0, 1'b0};
    tv[6] = '{1'b0, 32'h5555_5555, 40, 0, 1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b1, 32'h0000_0000, 20, 1, 1'b1, 1'b0, 1'b0};
    tv[8] = '{1'b0, 32'h1234_5678, 33, 1, 1'b0, 1'b0, 1'b1};
    tv[9] = '{1'b1, 32'h0BAD_F00D, 40, 1, 1'b1, 1'b0, 1'b0};
    exp_a = '{{1'b0, 32'hA5A5_0F0F}, {1'b1, 32'hFFFF_FFFE},
              {1'b0, 32'h1111_1111}, {1'b1, 32'h2222_2222},
              {1'b0, 32'h3333_3333}, {1'b1, 32'h4444_4444},
              {1'b0, 32'h1234_5678}, {1'b1, 32'h0BAD_F00D}};
    exp_b = '{{1'b1, 32'hA2A2_0002}, {1'b0, 32'hA3A3_0003},
              {1'b1, 32'hA4A4_0004}, {1'b0, 32'hA5A5_0005}};

    mif.m_ready = 1'b0;
    do_reset();
    chk_en = 1'b1;
    check("rst m_valid", 64'(mif.m_valid), 64'd0);
    check("rst m_data", 64'(mif.m_data), 64'd0);
    check("rst m_chan", 64'(mif.m_chan), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst frame_err", 64'(frame_err), 64'd0);
    check("rst peak_abs", 64'(peak_abs), 64'd0);

    got.delete();
    for (int i = 0; i < 10; i++) begin
      frame(tv[i].ch, tv[i].wd, tv[i].len, tv[i].rdy, tv[i].clr, -1);
      check($sformatf("row%0d overflow", i), 64'(overflow),
            64'(tv[i].e_ovf));
      check($sformatf("row%0d frame_err", i), 64'(frame_err),
            64'(tv[i].e_fe));
    end
    check("table count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got.size())
        check($sformatf("table word%0d", i), 64'(got[i]),
              64'(exp_a[i]));

    // full FIFO, consumer pops in the push cycle
    got.delete();
    frame(1'b0, 32'hA1A1_0001, 40, 0, 1'b0, -1);
    frame(1'b1, 32'hA2A2_0002, 40, 0, 1'b0, -1);
    frame(1'b0, 32'hA3A3_0003, 40, 0, 1'b0, -1);
    frame(1'b1, 32'hA4A4_0004, 40, 0, 1'b0, -1);
    frame(1'b0, 32'hA5A5_0005, 40, 0, 1'b0, BO + W);
    check("full pop overflow", 64'(overflow), 64'd0);
    check("full pop valid", 64'(mif.m_valid), 64'd1);
    frame(1'b0, 32'h0, 10, 1, 1'b0, -1);
    check("full pop count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 4; i++)
      if (i + 1 < got.size())
        check($sformatf("full pop word%0d", i), 64'(got[i+1]),
              64'(exp_b[i]));

    // reset in the middle of SHIFT
    frame(1'b1, 32'hB1B1_0001, 40, 0, 1'b0, -1);
    frame(1'b0, 32'hB2B2_0002, 15, 0, 1'b0, -1);
    do_reset();
    check("midrst valid", 64'(mif.m_valid), 64'd0);
    check("midrst overflow", 64'(overflow), 64'd0);
    got.delete();
    frame(1'b0, 32'h0, 30, 1, 1'b0, -1);
    check("midrst no push", 64'(got.size()), 64'd0);
    frame(1'b1, 32'hCAFE_F00D, 40, 1, 1'b0, -1);
    check("midrst resume count", 64'(got.size()), 64'd1);
    if (got.size() > 0)
      check("midrst resume word", 64'(got[0]),
            64'({1'b1, 32'hCAFE_F00D}));
    check("midrst frame_err", 64'(frame_err), 64'd0);

    do_reset();
    frame(1'b0, 32'h0000_0100, 40, 1, 1'b0, -1);
`ifdef I2S_FRAME_RX_PEAK_EN
    check("peak 0x100", 64'(peak_abs), 64'h100);
`else
    check("peak off", 64'(peak_abs), 64'h0);
`endif
    frame(1'b1, 32'hFFFF_FF00, 40, 1, 1'b0, -1);
`ifdef I2S_FRAME_RX_PEAK_EN
    check("peak -0x100", 64'(peak_abs), 64'h100);
`else
    check("peak off", 64'(peak_abs), 64'h0);
`endif
    frame(1'b0, 32'h8000_0000, 40, 1, 1'b0, -1);
`ifdef I2S_FRAME_RX_PEAK_EN
    check("peak most-neg", 64'(peak_abs), 64'h7FFF_FFFF);
`else
    check("peak off", 64'(peak_abs), 64'h0);
`endif

    for (int i = 0; i < 60; i++)
      frame(~lr_clk, W'($urandom), int'($urandom_range(25, 45)),
            2, ($urandom % 8) == 0, -1);
    frame(lr_clk, 32'h0, 20, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
